// File: rtl/if_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int PC_STEP = 4;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module if_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, stall/flush handling.
// Define IF_PERF_CNT_EN to make stall_cnt_o/flush_cnt_o live; otherwise they are tied to 0.
module if_stage
  import if_pkg::*;
#(
  parameter int                 XLEN       = if_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC   = '0,
  parameter int                 IMEM_DEPTH = 256,
  parameter int                 CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic [31:0]      imem_instr_i,
  output logic [XLEN-1:0]  imem_addr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(IMEM_DEPTH);

  // Pipeline control: stall_i holds everything and outranks flush_i; flush_i
  // redirects the PC and squashes IF/ID; both are sampled only while running.
  if_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [31:0]     ifid_instr_q;
  logic            ifid_valid_q;
  logic            fetch_in_range;
  logic            unused_tgt_lsbs;

  assign fetch_in_range  = ({2'b00, pc_q[XLEN-1:2]} < DEPTH_W);
  assign unused_tgt_lsbs = ^branch_target_i[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IF_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (!start_i) begin
      state_q      <= IF_IDLE;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      // The IDLE->RUN edge already acts as a running cycle.
      state_q <= IF_RUN;
      if (stall_i) begin
        pc_q <= pc_q;
      end else if (flush_i) begin
        pc_q         <= {branch_target_i[XLEN-1:2], 2'b00};
        ifid_pc_q    <= '0;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
      end else begin
        pc_q <= pc_q + XLEN'(PC_STEP);
        if (fetch_in_range) begin
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= imem_instr_i;
          ifid_valid_q <= 1'b1;
        end else begin
          ifid_pc_q    <= '0;
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end
      end
    end
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // Events only count on cycles that behave as running cycles.
  assign stall_inc = start_i & stall_i;
  assign flush_inc = start_i & flush_i & ~stall_i;

  if_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  if_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async reset, saturation, and random run vs a model.
module tb_if_stage;

  localparam int CW    = 4;
  localparam int DEPTH = 256;
  localparam logic [31:0] INS_A = 32'h1111_1113;
  localparam logic [31:0] INS_B = 32'h2222_2223;
  localparam logic [31:0] INS_C = 32'h3333_3333;
  localparam logic [31:0] INS_D = 32'h4444_4443;
  localparam logic [31:0] INS_E = 32'h5555_5553;
  localparam logic [31:0] INS_F = 32'h6666_6663;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [31:0]   branch_target_i = '0;
  logic [31:0]   imem_instr_i;
  logic [31:0]   imem_addr_o;
  logic [31:0]   pc_o;
  logic [31:0]   ifid_pc_o;
  logic [31:0]   ifid_instr_o;
  logic          ifid_valid_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] imem_mem [DEPTH];

  // Memory aliases on the low index bits so out-of-range fetches see nonzero data.
  assign imem_instr_i = imem_mem[imem_addr_o[9:2]];

  if_stage #(
    .XLEN(32), .RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_instr_i(imem_instr_i), .imem_addr_o(imem_addr_o), .pc_o(pc_o),
    .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st, sl, fl;
    logic [31:0] tg;
    logic [31:0] pc, ipc, ins;
    logic        val;
    logic [3:0]  sc, fc;
  } vec_t;

  vec_t tbl [18];

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        m_val;
  int          m_sc, m_fc;
  bit          m_run;

  function automatic logic [3:0] perf(input int v);
`ifdef IF_PERF_CNT_EN
    return 4'(v);
`else
    return (v < 0) ? 4'hF : 4'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] ins, input logic val,
                           input logic [3:0] sc, input logic [3:0] fc);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".addr"}, imem_addr_o, pc);
    check({tag, ".ifid_pc"}, ifid_pc_o, ipc);
    check({tag, ".ifid_instr"}, ifid_instr_o, ins);
    check({tag, ".ifid_valid"}, {31'b0, ifid_valid_o}, {31'b0, val});
    check({tag, ".stall_cnt"}, {28'b0, stall_cnt_o}, {28'b0, sc});
    check({tag, ".flush_cnt"}, {28'b0, flush_cnt_o}, {28'b0, fc});
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled 1 unit after the next.
  task automatic drive_edge(input logic st, input logic sl, input logic fl, input logic [31:0] tg);
    start_i = st; stall_i = sl; flush_i = fl; branch_target_i = tg;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = '0; m_ins = '0; m_val = 1'b0;
    m_sc = 0; m_fc = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic st, input logic sl, input logic fl, input logic [31:0] tg);
    int cap;
    cap = (1 << CW) - 1;
    m_run = st;
    if (!st) begin
      m_ipc = '0; m_ins = '0; m_val = 1'b0;
    end else if (sl) begin
      if (m_sc < cap) m_sc++;
    end else if (fl) begin
      m_pc = tg & 32'hFFFF_FFFC;
      m_ipc = '0; m_ins = '0; m_val = 1'b0;
      if (m_fc < cap) m_fc++;
    end else begin
      if ((m_pc / 4) < DEPTH) begin
        m_ipc = m_pc; m_ins = imem_mem[m_pc / 4]; m_val = 1'b1;
      end else begin
        m_ipc = '0; m_ins = '0; m_val = 1'b0;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) imem_mem[i] = $urandom | 32'h1;
    imem_mem[0] = INS_A; imem_mem[1] = INS_B; imem_mem[2] = INS_C;
    imem_mem[8] = INS_D; imem_mem[9] = 32'h0;
    imem_mem[254] = INS_E; imem_mem[255] = INS_F;

    //           st    sl    fl    target        pc            ifid_pc       instr  val   sc    fc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        INS_A, 1'b1, 4'd0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        INS_B, 1'b1, 4'd0, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        INS_B, 1'b1, 4'd1, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        INS_B, 1'b1, 4'd2, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        INS_C, 1'b1, 4'd2, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h22,       32'h20,       32'h0,        32'h0, 1'b0, 4'd2, 4'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h100,      32'h20,       32'h0,        32'h0, 1'b0, 4'd3, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h24,       32'h20,       INS_D, 1'b1, 4'd3, 4'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'h0,        32'h0, 1'b0, 4'd3, 4'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h24,       32'h0,        32'h0, 1'b0, 4'd3, 4'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h28,       32'h24,       32'h0, 1'b1, 4'd3, 4'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h3FB,      32'h3F8,      32'h0,        32'h0, 1'b0, 4'd3, 4'd2};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h3FC,      32'h3F8,      INS_E, 1'b1, 4'd3, 4'd2};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h400,      32'h3FC,      INS_F, 1'b1, 4'd3, 4'd2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h404,      32'h0,        32'h0, 1'b0, 4'd3, 4'd2};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0,        32'h0, 1'b0, 4'd3, 4'd3};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0, 1'b0, 4'd3, 4'd3};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        INS_A, 1'b1, 4'd3, 4'd3};

    // Reset state
    #2;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    do_reset();
    check_all("post_reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      drive_edge(tbl[i].st, tbl[i].sl, tbl[i].fl, tbl[i].tg);
      check_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].ipc, tbl[i].ins, tbl[i].val,
                perf(int'(tbl[i].sc)), perf(int'(tbl[i].fc)));
    end

    // Async reset between edges while running
    drive_edge(1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    rst_i = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_all("async_rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);

    // Counter saturation: 20 stalls on a 4-bit counter
    drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) drive_edge(1'b1, 1'b1, 1'b0, 32'h0);
    check_all("stall_sat", 32'h4, 32'h0, INS_A, 1'b1, perf(15), perf(0));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic st, sl, fl;
      logic [31:0] tg;
      st = ($urandom_range(0, 15) != 0);
      sl = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      tg = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      if (!st || !m_run) begin
        sl = 1'b0; fl = 1'b0;
      end
      model_edge(st, sl, fl, tg);
      drive_edge(st, sl, fl, tg);
      check_all($sformatf("rand%0d", i), m_pc, m_ipc, m_ins, m_val, perf(m_sc), perf(m_fc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Applies stall from hazard detection and branch redirect/flush from ID.
- Optionally exports stall/flush event counts so the testbench stops hand-counting them.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0, PC value after reset.
- IMEM_DEPTH, 256, instruction-memory depth in words; fetches at or beyond this index return a bubble.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  run enable (level).
- stall_i  in  1  load-use stall from hazard detection; hold PC and IF/ID.
- flush_i  in  1  branch taken in ID; redirect PC and squash IF/ID.
- branch_target_i  in  XLEN  redirect address.
- imem_instr_i  in  32  instruction word at imem_addr_o (combinational read).
- imem_addr_o  out  XLEN  fetch address (= pc_o).
- pc_o  out  XLEN  current PC.
- ifid_pc_o  out  XLEN  PC of the instruction in IF/ID.
- ifid_instr_o  out  32  instruction in IF/ID; 32'b0 is a bubble.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- stall_cnt_o  out  CNT_W  stall-cycle count (see Optional Feature).
- flush_cnt_o  out  CNT_W  flush count (see Optional Feature).

Behaviour:
- Reset (async, immediate, including mid-operation):
  - pc_o=RESET_PC; ifid_pc_o=0; ifid_instr_o=0; ifid_valid_o=0.
  - Counters=0; state=IDLE.
- States:
  - IDLE: PC holds; IF/ID loads a bubble each cycle.
  - IDLE->RUN on the first posedge with start_i=1; that edge already performs a normal fetch.
  - RUN->IDLE on a posedge with start_i=0; that edge behaves as IDLE (bubble, PC hold).
- RUN, per posedge, in priority order:
  1. stall_i=1: PC and all IF/ID outputs hold. flush_i is ignored; hazard unit re-presents the branch next cycle.
  2. flush_i=1: pc<=branch_target_i with bits [1:0] forced to 00; IF/ID<=bubble (instr 0, valid 0, pc 0).
  3. Otherwise: pc<=pc+4, wrapping mod 2^XLEN (0xFFFFFFFC->0). IF/ID<={pc, imem_instr_i, 1}.
- Out-of-range fetch: if pc[XLEN-1:2] >= IMEM_DEPTH, IF/ID loads a bubble while PC still advances.
- Fetch of an all-zero word: loaded with valid=1, i.e. an architectural NOP.
- Latency: instruction at PC p appears on ifid_* exactly 1 cycle after pc_o=p, absent stall.
- imem_addr_o is combinational from the PC register.
- Counter events, counted only in RUN, saturating at all-ones, never wrapping:
  - stall_cnt: +1 per cycle with stall_i=1.
  - flush_cnt: +1 per cycle with flush_i=1 and stall_i=0.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: stall_cnt_o/flush_cnt_o are live per the counter rules above.
- Undefined: no counter flops; both ports are tied to 0.
- Port list is identical in both builds, so the CPU top and testbench hierarchy are unchanged.

Decomposition:
- Shared package if_pkg:
  - XLEN.
  - NOP_INSTR=32'b0.
  - PC_STEP=4.
  - fetch-state encoding IF_IDLE/IF_RUN.
- One sub-module, if_sat_counter (CNT_W, clk_i, rst_i, inc_i, cnt_o): saturating incrementer, instantiated twice under IF_PERF_CNT_EN.

Test Plan:
- Reset then start_i=1 with imem[0..2]=A,B,C:
  - cycle 1: pc_o=4, ifid=A/pc 0/valid 1.
  - cycle 2: pc_o=8, ifid=B.
- stall_i=1 for 2 cycles at pc=8:
  - pc_o stays 8 and ifid stays B throughout.
  - stall_cnt=2.
  - release: ifid=C, pc_o=12.
- flush_i=1 with branch_target_i=0x22 at pc=12:
  - next pc_o=0x20; ifid_instr_o=0, valid 0.
  - flush_cnt=1.
- stall_i=1 and flush_i=1 together:
  - PC and IF/ID hold.
  - stall_cnt+1, flush_cnt unchanged.
- Wrap and out-of-range:
  - Run to pc=0x3FC with IMEM_DEPTH=256: ifid gets imem[255].
  - Next fetch at 0x400: bubble.
  - Force pc=0xFFFFFFFC: next pc_o=0.
- Async reset mid-RUN:
  - Assert rst_i between clock edges: outputs return to reset values before the next posedge.
  - Counters force to 0; CNT_W=4 bench: 20 stalls give stall_cnt=15.
